draw_req_sched: RTL and testbench
=================================

DRAW_REQ_SCHED -- requirements
Module: draw_req_sched

Interface
REQ-001 Parameter DEPTH, default 4: draw-request FIFO depth, power of two.
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles spent waiting on any single done edge.
REQ-003 LCD_CLK  in  1  clock; all logic is on the rising edge.
REQ-004 RESETN  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  game logic offers a draw request.
REQ-006 req_pos  in  6  target cell {page[5:3], column group[2:0]}.
REQ-007 req_image  in  2  cell image code (0 empty, 1 player A, 2 player B, 3 highlight).
REQ-008 req_ready  out  1  FIFO can accept a request this cycle.
REQ-009 pos  out  6  cell position driven to the LCD drawer.
REQ-010 image  out  2  image code driven to the LCD drawer.
REQ-011 done  in  1  drawer status; 1 means idle, 0 means drawing.
REQ-012 busy  out  1  requests are pending or a draw is in flight.
REQ-013 err  out  1  sticky flag; set when a draw times out.
REQ-014 level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 The block SHALL accept a request when req_valid && req_ready; req_ready = (level < DEPTH) and depends only on registered occupancy, with no same-cycle bypass.
REQ-016 The FIFO SHALL preserve order. A simultaneous push and pop SHALL leave level unchanged. A push while full SHALL be ignored.
REQ-017 The state machine SHALL have the states BOOT, IDLE, WAIT_START and WAIT_DONE, plus a registered kick flag.
REQ-018 BOOT: on the first cycle with done==1, the block SHALL move to IDLE; requests may be queued while in BOOT.
REQ-019 IDLE with level>0: the block SHALL pop the head into cur_pos/cur_img and drive pos=cur_pos in the next cycle.
- If cur_img != last_img: image=cur_img, kick=0.
- Else: image=~cur_img, kick=1 (the drawer redraws only on an image change).
- Next state: WAIT_START.
REQ-020 WAIT_START: on done==0 the block SHALL go to WAIT_DONE.
REQ-021 WAIT_DONE: on done==1, behaviour SHALL depend on the kick flag.
- kick=1: image=cur_img, kick=0, go to WAIT_START.
- kick=0: last_img=cur_img, go to IDLE.
REQ-022 pos and image SHALL remain stable from issue until the matching done rise.
REQ-023 Latency: a request pushed into an empty FIFO in IDLE at cycle n SHALL appear on pos/image at cycle n+2.
REQ-024 A 16-bit wait counter SHALL clear on every entry to WAIT_START or WAIT_DONE.
- On reaching TIMEOUT: err=1, last_img=current image output, kick=0, go to IDLE, discard the request, leave the FIFO untouched.
REQ-025 busy SHALL equal (state is WAIT_START or WAIT_DONE) || level!=0.
REQ-026 A done glitch to 0 while in IDLE SHALL be ignored.

Reset
REQ-027 Asserting RESETN low SHALL asynchronously force the following values:
- state=BOOT, FIFO empty (level=0), req_ready=1.
- pos=0, image=0, last_img=0, kick=0.
- err=0, busy=0, wait counter=0.
REQ-028 Reset mid-draw SHALL abandon the request in flight and flush all queued requests.

Structure
REQ-029 A shared package (draw_pkg) SHALL hold the state encoding, the image-code constants (EMPTY, PLAYER_A, PLAYER_B, HIGHLIGHT) and the DEPTH/TIMEOUT defaults.
REQ-030 The FIFO SHALL be one sub-module, draw_req_fifo.
- Storage: 8-bit entries {pos, image}, wrap-around read/write pointers.
- Exports: level, full and empty.
REQ-031 The scheduler FSM, kick logic and timeout SHALL live in draw_req_sched; expected size is 150-300 lines of RTL.

Verification
REQ-032 Boot gating: done=0 for 20 cycles with one request (pos=6'o12, image=1) queued -> pos/image stay 0/0; after done rises -> pos=6'o12, image=1 two cycles later.
REQ-033 Normal draw: drawer model drops done 3 cycles after an image change and raises it 10 cycles later -> exactly one draw occurs, last_img=1, state returns to IDLE, busy=0.
REQ-034 Same-image kick: two requests (6'o05, 2) and then (6'o06, 2) -> second request produces image=1 (~2) at pos 6'o06, then image=2 at the same pos; pos is stable across both draws.
REQ-035 Full FIFO: push 5 requests back-to-back with the drawer stalled (DEPTH=4) -> req_ready=0 after the 4th, 5th dropped, level=4; simultaneous push and pop when full keeps level=4.
REQ-036 Timeout: done held at 1 after issue for TIMEOUT cycles -> err=1 sticky, block proceeds to the next queued request, busy tracks the queue.
REQ-037 Reset mid-draw: RESETN pulsed low in WAIT_DONE with level=3 -> outputs immediately take REQ-027 values, state=BOOT.

Source files
------------

// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// draw_pkg : shared types and constants for the LCD draw-request scheduler
// Rev 1.0  : initial release
// ============================================================================
package draw_pkg;

  localparam int DEPTH_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 4096;
  localparam int WAIT_CNT_W      = 16;

  localparam logic [1:0] EMPTY     = 2'd0;
  localparam logic [1:0] PLAYER_A  = 2'd1;
  localparam logic [1:0] PLAYER_B  = 2'd2;
  localparam logic [1:0] HIGHLIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_IDLE       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [5:0] pos;
    logic [1:0] img;
  } draw_req_t;

  // The drawer only acts on an image change, so a repeat is first sent inverted.
  function automatic logic [1:0] first_image(input logic [1:0] img, input logic [1:0] last);
    return (img != last) ? img : ~img;
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_req_fifo.sv
`default_nettype none
// ============================================================================
// draw_req_fifo : power-of-two request FIFO with wrap-around pointers
// Rev 1.0       : initial release
// ============================================================================
module draw_req_fifo
  import draw_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          LCD_CLK,
  input  logic          RESETN,
  input  logic          push_i,
  input  draw_req_t     wdata_i,
  input  logic          pop_i,
  output draw_req_t     rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  draw_req_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge LCD_CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/draw_req_sched.sv
`default_nettype none
// ============================================================================
// draw_req_sched : queues cell draw requests and sequences them to the LCD drawer
// Rev 1.0        : initial release
// ============================================================================
module draw_req_sched
  import draw_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEFAULT,
  parameter int  TIMEOUT = TIMEOUT_DEFAULT,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic          LCD_CLK,
  input  logic          RESETN,
  input  logic          req_valid,
  input  logic [5:0]    req_pos,
  input  logic [1:0]    req_image,
  output logic          req_ready,
  output logic [5:0]    pos,
  output logic [1:0]    image,
  input  logic          done,
  output logic          busy,
  output logic          err,
  output logic [LW-1:0] level
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  sched_state_t          state_q;
  logic [5:0]            pos_q;
  logic [1:0]            img_q;
  logic [1:0]            cur_img_q;
  logic [1:0]            last_img_q;
  logic                  kick_q;
  logic                  err_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  draw_req_t             fifo_wdata;
  draw_req_t             fifo_head;
  logic [LW-1:0]         fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  wait_expired;
  logic                  in_flight;

  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign fifo_wdata = '{pos: req_pos, img: req_image};
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

  draw_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .LCD_CLK (LCD_CLK),
    .RESETN  (RESETN),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wait_expired = (wait_cnt_q == TIMEOUT_LAST);
  assign in_flight    = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_DONE);

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_BOOT;
      pos_q      <= '0;
      img_q      <= EMPTY;
      cur_img_q  <= EMPTY;
      last_img_q <= EMPTY;
      kick_q     <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (done) state_q <= ST_IDLE;
        end

        // done is deliberately not looked at here, so idle glitches are harmless.
        ST_IDLE: begin
          if (!fifo_empty) begin
            pos_q      <= fifo_head.pos;
            cur_img_q  <= fifo_head.img;
            img_q      <= first_image(fifo_head.img, last_img_q);
            kick_q     <= (fifo_head.img == last_img_q);
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT_START;
          end
        end

        ST_WAIT_START: begin
          if (!done) begin
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT_DONE;
          end else if (wait_expired) begin
            err_q      <= 1'b1;
            last_img_q <= img_q;
            kick_q     <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (done) begin
            wait_cnt_q <= '0;
            if (kick_q) begin
              // Inverted dummy draw finished; now send the real image.
              img_q   <= cur_img_q;
              kick_q  <= 1'b0;
              state_q <= ST_WAIT_START;
            end else begin
              last_img_q <= cur_img_q;
              state_q    <= ST_IDLE;
            end
          end else if (wait_expired) begin
            err_q      <= 1'b1;
            last_img_q <= img_q;
            kick_q     <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign pos   = pos_q;
  assign image = img_q;
  assign err   = err_q;
  assign level = fifo_level;
  assign busy  = in_flight || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_draw_req_sched.sv
`default_nettype none
// ============================================================================
// tb_draw_req_sched : directed + random bench with a transaction-level drawer model
// Rev 1.0           : initial release
// ============================================================================
module tb_draw_req_sched;
  import draw_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 64;
  localparam int LW       = 3;
  localparam int M_NORMAL = 0;
  localparam int M_LOW    = 1;
  localparam int M_HIGH   = 2;
  localparam int LIMIT    = 3000;

  logic          LCD_CLK   = 1'b0;
  logic          RESETN    = 1'b1;
  logic          req_valid = 1'b0;
  logic [5:0]    req_pos   = '0;
  logic [1:0]    req_image = '0;
  logic          req_ready;
  logic [5:0]    pos;
  logic [1:0]    image;
  logic          done      = 1'b0;
  logic          busy;
  logic          err;
  logic [LW-1:0] level;

  int total = 0;
  int bad   = 0;

  // Model: accepted requests, draws still expected for the request in flight.
  logic [7:0] req_q[$];
  logic [7:0] draw_q[$];
  logic [1:0] mdl_last  = 2'd0;
  logic       mdl_err   = 1'b0;
  int         mode      = M_LOW;
  logic       active    = 1'b0;
  int         t         = 0;
  logic [5:0] start_pos = '0;
  logic [1:0] img_prev  = '0;
  logic       pend_acc  = 1'b0;
  logic [7:0] pend_req  = '0;

  draw_req_sched #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .LCD_CLK   (LCD_CLK),
    .RESETN    (RESETN),
    .req_valid (req_valid),
    .req_pos   (req_pos),
    .req_image (req_image),
    .req_ready (req_ready),
    .pos       (pos),
    .image     (image),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .level     (level)
  );

  always #5 LCD_CLK = ~LCD_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drawer: every image change is a draw; done drops shortly after and rises 10 cycles later.
  task automatic drawer_update();
    logic [7:0] r;
    if (image !== img_prev) begin
      if (draw_q.size() == 0) begin
        chk("issue_has_req", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          if (r[1:0] != mdl_last) draw_q.push_back(r);
          else begin
            draw_q.push_back({r[7:2], ~r[1:0]});
            draw_q.push_back(r);
          end
        end
      end
      if (draw_q.size() != 0) begin
        chk("issue_pos", 32'(pos), 32'(draw_q[0][7:2]));
        chk("issue_img", 32'(image), 32'(draw_q[0][1:0]));
      end
      if (mode != M_HIGH) begin
        active    = 1'b1;
        start_pos = pos;
        t         = (mode == M_LOW) ? 3 : 0;
      end
    end
    img_prev = image;
    if (active) begin
      if (mode != M_LOW) t++;
      if (t >= 3) done = 1'b0;
      if (t == 13) begin
        done   = 1'b1;
        active = 1'b0;
        chk("pos_stable", 32'(pos), 32'(start_pos));
        chk("draw_expected", 32'(draw_q.size() != 0), 32'd1);
        if (draw_q.size() != 0) begin
          chk("draw_pos", 32'(pos), 32'(draw_q[0][7:2]));
          chk("draw_img", 32'(image), 32'(draw_q[0][1:0]));
          if (draw_q.size() == 1) mdl_last = draw_q[0][1:0];
          r = draw_q.pop_front();
        end
      end
    end else begin
      done = (mode != M_LOW);
    end
  endtask

  task automatic cyc();
    @(posedge LCD_CLK);
    #1;
    drawer_update();
    if (pend_acc) begin
      req_q.push_back(pend_req);
      pend_acc = 1'b0;
    end
    if (RESETN) chk("level", 32'(level), 32'(req_q.size()));
  endtask

  task automatic push(input logic [5:0] p, input logic [1:0] im);
    chk("ready", 32'(req_ready), 32'(req_q.size() < DEPTH));
    req_valid = 1'b1;
    req_pos   = p;
    req_image = im;
    pend_acc  = (req_q.size() < DEPTH);
    pend_req  = {p, im};
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((req_q.size() != 0 || draw_q.size() != 0 || busy) && n < LIMIT) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n >= LIMIT), 32'd0);
    chk("drained_busy", 32'(busy), 32'd0);
    chk("err_flag", 32'(err), 32'(mdl_err));
  endtask

  task automatic apply_reset();
    RESETN = 1'b0;
    #1;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_image", 32'(image), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    req_q.delete();
    draw_q.delete();
    mdl_last = 2'd0;
    mdl_err  = 1'b0;
    active   = 1'b0;
    img_prev = 2'd0;
    pend_acc = 1'b0;
    repeat (3) cyc();
    RESETN = 1'b1;
  endtask

  task automatic timeout_seen();
    if (draw_q.size() != 0) mdl_last = draw_q[0][1:0];
    draw_q.delete();
    mdl_err = 1'b1;
  endtask

  initial begin
    int n;
    mode = M_LOW;
    done = 1'b0;
    #2;
    apply_reset();

    // Boot gating: request waits until done first rises.
    push(6'o12, PLAYER_A);
    repeat (20) cyc();
    chk("boot_pos", 32'(pos), 32'd0);
    chk("boot_img", 32'(image), 32'd0);
    chk("boot_busy", 32'(busy), 32'd1);
    mode = M_NORMAL;
    done = 1'b1;
    cyc();
    chk("boot_hold_pos", 32'(pos), 32'd0);
    cyc();
    chk("boot_issue_pos", 32'(pos), 32'o12);
    chk("boot_issue_img", 32'(image), 32'(PLAYER_A));
    drain("drain_boot");

    // Two-cycle latency, then a same-image request that needs a kick.
    push(6'o05, PLAYER_B);
    chk("lat_hold_pos", 32'(pos), 32'o12);
    cyc();
    chk("lat_pos", 32'(pos), 32'o05);
    chk("lat_img", 32'(image), 32'(PLAYER_B));
    push(6'o06, PLAYER_B);
    n = 0;
    while (pos !== 6'o06 && n < 200) begin
      cyc();
      n++;
    end
    chk("kick_reach", 32'(n >= 200), 32'd0);
    chk("kick_first_img", 32'(image), 32'(PLAYER_A));
    drain("drain_kick");

    // Full FIFO with the drawer stalled mid-draw.
    mode = M_LOW;
    push(6'o20, HIGHLIGHT);
    repeat (3) cyc();
    for (int i = 0; i < 5; i++) push(6'(24 + i), 2'(i));
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    mode = M_NORMAL;
    drain("drain_full");

    // Timeout: done never falls for the first request.
    mode = M_HIGH;
    push(6'o41, PLAYER_A);
    push(6'o42, PLAYER_A);
    repeat (TIMEOUT - 1) cyc();
    chk("to_err_early", 32'(err), 32'd0);
    cyc();
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    timeout_seen();
    mode = M_NORMAL;
    drain("drain_timeout");

    // Random traffic against the model.
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 1) == 1) push(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      else cyc();
    end
    drain("drain_rand");

    // Reset in the middle of a draw with three requests queued.
    mode = M_LOW;
    push(6'o50, PLAYER_B);
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) push(6'(52 + i), 2'(i + 1));
    chk("pre_rst_level", 32'(level), 32'd3);
    apply_reset();
    push(6'o51, HIGHLIGHT);
    repeat (5) cyc();
    chk("reboot_pos", 32'(pos), 32'd0);
    mode = M_NORMAL;
    done = 1'b1;
    cyc();
    cyc();
    chk("reboot_issue_pos", 32'(pos), 32'o51);
    chk("reboot_issue_img", 32'(image), 32'(HIGHLIGHT));
    drain("drain_reboot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
